// File: rtl/serial_shift_unit.sv
// Multi-cycle serial shifter: one bit position per clock,
// with a Start/Busy/Done handshake to the control unit.
module serial_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Operand,
  input  logic [AMT_W-1:0] Amount,
  input  logic             Dir,
  input  logic             Arith,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ari_q, ari_d;
  logic             rot_q, rot_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] step_w;
  logic             step_c;

  // one-position step of the working register
  always_comb begin
    step_w = w_q;
    step_c = 1'b0;
    unique case (1'b1)
      !dir_q && !rot_q: begin
        step_w = {w_q[WIDTH-2:0], 1'b0};
        step_c = w_q[WIDTH-1];
      end
      !dir_q && rot_q: begin
        step_w = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
        step_c = w_q[WIDTH-1];
      end
      dir_q && rot_q: begin
        step_w = {w_q[0], w_q[WIDTH-1:1]};
        step_c = w_q[0];
      end
      dir_q && !rot_q && ari_q: begin
        step_w = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
        step_c = w_q[0];
      end
      dir_q && !rot_q && !ari_q: begin
        step_w = {1'b0, w_q[WIDTH-1:1]};
        step_c = w_q[0];
      end
      default: begin
        step_w = w_q;
        step_c = 1'b0;
      end
    endcase
  end

  // next-state: accept in IDLE, step in SHIFT, one-cycle DONE
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ari_d   = ari_q;
    rot_d   = rot_q;
    co_d    = co_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          w_d     = Operand;
          cnt_d   = Amount;
          dir_d   = Dir;
          ari_d   = Arith;
          rot_d   = Rotate;
          co_d    = 1'b0;
          state_d = (Amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_d   = step_w;
        co_d  = step_c;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ari_q   <= 1'b0;
      rot_q   <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ari_q   <= ari_d;
      rot_q   <= rot_d;
      co_q    <= co_d;
    end
  end

  assign Result   = w_q;
  assign CarryOut = co_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed vector bench for serial_shift_unit.
// Vectors carry hand-computed results; corner cases are sequenced by hand.
module tb_serial_shift_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Operand = '0;
  logic [2:0] Amount = '0;
  logic       Dir = 1'b0;
  logic       Arith = 1'b0;
  logic       Rotate = 1'b0;
  logic [7:0] Result;
  logic       CarryOut;
  logic       Busy;
  logic       Done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .Operand(Operand), .Amount(Amount), .Dir(Dir),
    .Arith(Arith), .Rotate(Rotate), .Result(Result),
    .CarryOut(CarryOut), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] op;
    logic [2:0] amt;
    logic       dir;
    logic       ari;
    logic       rot;
    logic [7:0] exp_r;
    logic       exp_c;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int  k;
    int  nbusy;
    bit  seen;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge CLK);
    Operand = v.op;
    Amount  = v.amt;
    Dir     = v.dir;
    Arith   = v.ari;
    Rotate  = v.rot;
    Start   = 1'b1;
    @(posedge CLK);
    #1;
    Start   = 1'b0;
    Operand = 8'h00;
    Amount  = 3'd0;
    k = 0;
    nbusy = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      if (Busy) nbusy++;
      if (Done) begin
        seen = 1;
        k = i;
      end
    end
    check({nm, " latency"}, k, 32'(v.amt) + 1);
    check({nm, " busy"}, nbusy, 32'(v.amt) + 1);
    check({nm, " result"}, 32'(Result), 32'(v.exp_r));
    check({nm, " carry"}, 32'(CarryOut), 32'(v.exp_c));
    @(negedge CLK);
    check({nm, " done_pulse"}, {Done, Busy}, 0);
    check({nm, " held"}, 32'(Result), 32'(v.exp_r));
  endtask

  vec_t vecs[11];
  int   nd;
  int   k;
  bit   seen;

  initial begin
    vecs[0]  = '{8'h96, 3'd3, 1'b0, 1'b0, 1'b0, 8'hB0, 1'b0};
    vecs[1]  = '{8'h96, 3'd2, 1'b1, 1'b1, 1'b0, 8'hE5, 1'b1};
    vecs[2]  = '{8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 8'h25, 1'b1};
    vecs[3]  = '{8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b1};
    vecs[4]  = '{8'h81, 3'd7, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0};
    vecs[5]  = '{8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[6]  = '{8'h80, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{8'h80, 3'd7, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{8'h80, 3'd7, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{8'h81, 3'd1, 1'b1, 1'b1, 1'b1, 8'hC0, 1'b1};
    vecs[10] = '{8'h96, 3'd3, 1'b0, 1'b1, 1'b0, 8'hB0, 1'b0};

    // reset held at time zero
    #12;
    check("rst_outputs", {Result, CarryOut, Busy, Done}, 0);
    @(negedge CLK);
    Reset = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge CLK);
      if (Done || Busy) nd++;
    end
    check("idle_no_done", nd, 0);

    foreach (vecs[i]) run_op(vecs[i], i);

    // reset pulse while idle with non-zero Result
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("idle_rst_outputs", {Result, CarryOut, Busy, Done}, 0);
    @(negedge CLK);
    Reset = 1'b1;

    // Start held high with a new Operand through SHIFT and DONE
    @(negedge CLK);
    Operand = 8'h96;
    Amount  = 3'd3;
    Dir     = 1'b0;
    Arith   = 1'b0;
    Rotate  = 1'b0;
    Start   = 1'b1;
    @(posedge CLK);
    #1;
    Operand = 8'hFF;
    Amount  = 3'd1;
    Dir     = 1'b1;
    seen = 0;
    k = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      if (Done) begin
        seen = 1;
        k = i;
      end
    end
    check("hold_latency", k, 4);
    check("hold_result", 32'(Result), 32'hB0);
    check("hold_carry", 32'(CarryOut), 0);
    Start = 1'b0;
    @(negedge CLK);
    check("hold_back_idle", {Busy, Done}, 0);
    check("hold_held", 32'(Result), 32'hB0);

    // reset asserted mid-SHIFT aborts without Done
    @(negedge CLK);
    Operand = 8'h81;
    Amount  = 3'd7;
    Dir     = 1'b0;
    Rotate  = 1'b1;
    Start   = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_busy", 32'(Busy), 1);
    Reset = 1'b0;
    #1;
    check("mid_rst_outputs", {Result, CarryOut, Busy, Done}, 0);
    @(negedge CLK);
    Reset = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge CLK);
      if (Done || Busy) nd++;
    end
    check("mid_no_done", nd, 0);

    // unit still works after abort
    run_op(vecs[3], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
